// File: rtl/conv_pool2x2.sv
// Streaming 2x2/stride-2 signed max-pool over a raster-order conv result stream.
// Optional ReLU on the input samples when CONV_POOL_RELU_EN is defined.
module conv_pool2x2 #(
    parameter  int IMG_W = 30,
    parameter  int IMG_H = 30,
    parameter  int DW    = 8,
    localparam int HW    = IMG_W / 2,
    localparam int HH    = IMG_H / 2,
    // A single pooled row/column still needs a 1-bit index port
    localparam int OCW   = (HW > 1) ? $clog2(HW) : 1,
    localparam int ORW   = (HH > 1) ? $clog2(HH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_vld,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_vld,
    output logic signed [DW-1:0] out_data,
    output logic [OCW-1:0]       out_col,
    output logic [ORW-1:0]       out_row,
    output logic                 frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]        col;
    logic [RW-1:0]        row;
    logic signed [DW-1:0] pair_reg;
    logic signed [DW-1:0] line_buf [HW];

    logic signed [DW-1:0] sample;
    logic signed [DW-1:0] hmax;
    logic signed [DW-1:0] lb_rd;
    logic signed [DW-1:0] pool;
    logic [OCW-1:0]       pidx;
    logic                 col_last;
    logic                 row_last;

    // Negative samples are clamped to zero before they enter the pooling datapath
    always_comb begin
        sample = in_data;
`ifdef CONV_POOL_RELU_EN
        if (in_data[DW-1]) begin
            sample = '0;
        end
`endif
    end

    assign pidx     = OCW'(col >> 1);
    assign col_last = (col == CW'(IMG_W - 1));
    assign row_last = (row == RW'(IMG_H - 1));
    assign lb_rd    = line_buf[pidx];
    assign hmax     = (pair_reg > sample) ? pair_reg : sample;
    assign pool     = (lb_rd > hmax) ? lb_rd : hmax;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            pair_reg   <= '0;
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_col    <= '0;
            out_row    <= '0;
            frame_done <= 1'b0;
        end else if (clr) begin
            col        <= '0;
            row        <= '0;
            pair_reg   <= '0;
            out_vld    <= 1'b0;
            out_data   <= '0;
            out_col    <= '0;
            out_row    <= '0;
            frame_done <= 1'b0;
        end else begin
            out_vld    <= 1'b0;
            frame_done <= 1'b0;
            if (in_vld) begin
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                if (!col[0]) begin
                    pair_reg <= sample;
                end else if (row[0]) begin
                    out_data   <= pool;
                    out_col    <= pidx;
                    out_row    <= ORW'(row >> 1);
                    out_vld    <= 1'b1;
                    frame_done <= col_last && row_last;
                end
            end
        end
    end

    // NOTE: the line buffer has no reset; every entry is written on an even row before it is read.
    always_ff @(posedge clk) begin
        if (in_vld && !clr && col[0] && !row[0]) begin
            line_buf[pidx] <= hmax;
        end
    end

endmodule
